// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse round engine: block width, legal
// round counts, FSM state encoding and the byte-level inverse cipher
// primitives (inverse S-box, InvShiftRows, AddRoundKey, InvMixColumns).
// Byte order: byte i of a block sits in bits [127-8*i -: 8], with
// i = row + 4*column (column-major state, byte 0 in the MSBs).
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int NR_AES128   = 10;
  localparam int NR_AES192   = 12;
  localparam int NR_AES256   = 14;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} inv_fsm_e;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = gf_xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0): product of a^2 .. a^128.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse S-box: undo the affine map, then take the field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] b;
    b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic aes_block_t inv_shift_rows(input aes_block_t s);
    aes_block_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic aes_block_t inv_sub_bytes(input aes_block_t s);
    aes_block_t o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic aes_block_t add_round_key(input aes_block_t s, input aes_block_t k);
    return s ^ k;
  endfunction

  function automatic aes_block_t inv_mix_columns(input aes_block_t s);
    aes_block_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gf_mul(s[127-8*(r+4*c) -: 8], 8'h0e)
                              ^ gf_mul(s[127-8*((r+1)%4+4*c) -: 8], 8'h0b)
                              ^ gf_mul(s[127-8*((r+2)%4+4*c) -: 8], 8'h0d)
                              ^ gf_mul(s[127-8*((r+3)%4+4*c) -: 8], 8'h09);
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round_engine_if.sv
// Block handshake bundle for the inverse round engine: ciphertext in and
// plaintext out, each with valid/ready. The engine itself keeps flat ports;
// this interface is how surrounding logic groups and connects them.
interface aes_inv_round_engine_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_block_t in_data;
  logic       out_valid;
  logic       out_ready;
  aes_block_t out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/aes_inv_round_dp.sv
// Combinational inverse AES round. With last=0 it is a full middle round
// (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns); with last=1 the
// InvMixColumns step is skipped for the final round.
module aes_inv_round_dp
  import aes_pkg::*;
(
  input  aes_block_t state,
  input  aes_block_t rk,
  input  logic       last,
  output aes_block_t next
);

  aes_block_t shifted;
  aes_block_t subbed;
  aes_block_t keyed;

  // One inverse round, built from the shared primitives in round order.
  always_comb begin
    shifted = inv_shift_rows(state);
    subbed  = inv_sub_bytes(shifted);
    keyed   = add_round_key(subbed, rk);
    next    = last ? keyed : inv_mix_columns(keyed);
  end

endmodule

// File: rtl/aes_inv_round_engine.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched
// through rk_idx/rk_data from an external key store (combinational read).
// Optional: define AES_INV_ENGINE_ABORT_EN to add an abort input that drops
// the block in flight and returns to IDLE.
module aes_inv_round_engine
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int RK_AW = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef AES_INV_ENGINE_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic [RK_AW-1:0]       rk_idx,
  input  logic [AES_BLOCK_W-1:0] rk_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);

  inv_fsm_e   fsm_q, fsm_d;
  aes_block_t blk_q, blk_d;
  logic [RK_AW-1:0] rnd_q, rnd_d;

  aes_block_t dp_next;
  logic       dp_last;

  aes_inv_round_dp u_dp (
    .state (blk_q),
    .rk    (rk_data),
    .last  (dp_last),
    .next  (dp_next)
  );

  // Registers: FSM state, working block and current round number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      blk_q <= '0;
      rnd_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      blk_q <= blk_d;
      rnd_q <= rnd_d;
    end
  end

  // Next-state, datapath select and handshake outputs for each FSM state.
  always_comb begin
    fsm_d     = fsm_q;
    blk_d     = blk_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    rk_idx    = '0;
    out_valid = 1'b0;
    out_data  = '0;
    dp_last   = 1'b0;
    busy      = (fsm_q != IDLE);
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        rk_idx   = RK_AW'(NR);
        if (in_valid) begin
          blk_d = add_round_key(in_data, rk_data);
          rnd_d = RK_AW'(NR - 1);
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        rk_idx = rnd_q;
        blk_d  = dp_next;
        rnd_d  = rnd_q - RK_AW'(1);
        if (rnd_q == RK_AW'(1)) fsm_d = FINAL;
      end
      FINAL: begin
        dp_last = 1'b1;
        blk_d   = dp_next;
        fsm_d   = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = blk_q;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
`ifdef AES_INV_ENGINE_ABORT_EN
    if (abort && (fsm_q != IDLE)) begin
      fsm_d = IDLE;
      blk_d = '0;
      rnd_d = '0;
    end
`endif
  end

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Directed bench for aes_inv_round_engine using FIPS-197 known-answer
// vectors. Two engines (NR=10 and NR=14) share clock and reset; round keys
// come from a key schedule computed here in the bench.
module tb_aes_inv_round_engine;

  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk;
  logic         rst_n;
  logic [3:0]   rk_idx10, rk_idx14;
  logic [127:0] rk_data10, rk_data14;
  logic         busy10, busy14;
`ifdef AES_INV_ENGINE_ABORT_EN
  logic         abort10, abort14;
`endif

  logic [127:0] rks10 [0:15];
  logic [127:0] rks14 [0:15];
  logic [31:0]  w [0:63];
  logic [7:0]   sbox_t [0:255];

  int checks;
  int errors;

  aes_inv_round_engine_if bus10();
  aes_inv_round_engine_if bus14();

  assign rk_data10 = rks10[rk_idx10];
  assign rk_data14 = rks14[rk_idx14];

  aes_inv_round_engine #(.NR(10), .RK_AW(4)) dut10 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_INV_ENGINE_ABORT_EN
    .abort(abort10),
`endif
    .in_valid(bus10.in_valid), .in_ready(bus10.in_ready), .in_data(bus10.in_data),
    .rk_idx(rk_idx10), .rk_data(rk_data10),
    .out_valid(bus10.out_valid), .out_ready(bus10.out_ready), .out_data(bus10.out_data),
    .busy(busy10)
  );

  aes_inv_round_engine #(.NR(14), .RK_AW(4)) dut14 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_INV_ENGINE_ABORT_EN
    .abort(abort14),
`endif
    .in_valid(bus14.in_valid), .in_ready(bus14.in_ready), .in_data(bus14.in_data),
    .rk_idx(rk_idx14), .rk_data(rk_data14),
    .out_valid(bus14.out_valid), .out_ready(bus14.out_ready), .out_data(bus14.out_data),
    .busy(busy14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tb_xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = tb_xtime(t);
    end
    return p;
  endfunction

  // Forward S-box table: brute-force field inverse followed by the affine map.
  task automatic build_sbox;
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (tb_mul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[a] = s;
    end
  endtask

  task automatic expand_key(input logic [255:0] key, input int nr);
    int nk;
    logic [31:0] t;
    logic [7:0] rcon;
    nk   = nr - 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = tb_xtime(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (nr == 14) rks14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else          rks10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one block to the NR=10 engine; returns 1 ns after the accepting edge.
  task automatic offer10(input logic [127:0] ct);
    bus10.in_data  = ct;
    bus10.in_valid = 1'b1;
    tick();
    bus10.in_valid = 1'b0;
  endtask

  task automatic wait_out10(output int cnt);
    cnt = 0;
    while (bus10.out_valid !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++; if (busy10 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy10); end
    checks++; if (bus10.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus10.in_ready); end
    checks++; if (rk_idx10 !== 4'd10) begin errors++; $display("[TB] FAIL reset_rk_idx10: got %0d expected 10", rk_idx10); end
    checks++; if (rk_idx14 !== 4'd14) begin errors++; $display("[TB] FAIL reset_rk_idx14: got %0d expected 14", rk_idx14); end
    checks++; if (bus10.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus10.out_valid); end
    checks++; if (bus10.out_data !== 128'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", bus10.out_data); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_aes128;
    int cnt;
    logic [3:0] exp_idx;
    expand_key(KEY_C1, 10);
    offer10(CT_C1);
    checks++; if (bus10.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL aes128_in_ready_busy: got %b expected 0", bus10.in_ready); end
    checks++; if (busy10 !== 1'b1) begin errors++; $display("[TB] FAIL aes128_busy: got %b expected 1", busy10); end
    cnt = 0;
    while (bus10.out_valid !== 1'b1 && cnt < 40) begin
      exp_idx = (cnt < 9) ? 4'(9 - cnt) : 4'd0;
      checks++; if (rk_idx10 !== exp_idx) begin errors++; $display("[TB] FAIL aes128_rk_idx[%0d]: got %0d expected %0d", cnt, rk_idx10, exp_idx); end
      tick();
      cnt++;
    end
    checks++; if (cnt != 10) begin errors++; $display("[TB] FAIL aes128_latency: got %0d expected 10", cnt); end
    checks++; if (bus10.out_data !== PT_C) begin errors++; $display("[TB] FAIL aes128_data: got %h expected %h", bus10.out_data, PT_C); end
    checks++; if (rk_idx10 !== 4'd0) begin errors++; $display("[TB] FAIL aes128_done_rk_idx: got %0d expected 0", rk_idx10); end
    tick();
    checks++; if (bus10.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL aes128_after_valid: got %b expected 0", bus10.out_valid); end
    checks++; if (bus10.out_data !== 128'h0) begin errors++; $display("[TB] FAIL aes128_after_data: got %h expected 0", bus10.out_data); end
    checks++; if (bus10.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL aes128_after_ready: got %b expected 1", bus10.in_ready); end
  endtask

  task automatic test_fips_b;
    int cnt;
    expand_key(KEY_B, 10);
    offer10(CT_B);
    wait_out10(cnt);
    checks++; if (cnt != 10) begin errors++; $display("[TB] FAIL fipsb_latency: got %0d expected 10", cnt); end
    checks++; if (bus10.out_data !== PT_B) begin errors++; $display("[TB] FAIL fipsb_data: got %h expected %h", bus10.out_data, PT_B); end
    tick();
  endtask

  task automatic test_aes256;
    int cnt;
    expand_key(KEY_C3, 14);
    bus14.in_data  = CT_C3;
    bus14.in_valid = 1'b1;
    tick();
    bus14.in_valid = 1'b0;
    cnt = 0;
    while (bus14.out_valid !== 1'b1 && cnt < 60) begin
      tick();
      cnt++;
    end
    checks++; if (cnt != 14) begin errors++; $display("[TB] FAIL aes256_latency: got %0d expected 14", cnt); end
    checks++; if (bus14.out_data !== PT_C) begin errors++; $display("[TB] FAIL aes256_data: got %h expected %h", bus14.out_data, PT_C); end
    tick();
    checks++; if (bus14.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL aes256_after_valid: got %b expected 0", bus14.out_valid); end
  endtask

  task automatic test_backpressure;
    int cnt, seen;
    expand_key(KEY_C1, 10);
    bus10.out_ready = 1'b0;
    offer10(CT_C1);
    wait_out10(cnt);
    checks++; if (cnt != 10) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected 10", cnt); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus10.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", i, bus10.out_valid); end
      checks++; if (bus10.out_data !== PT_C) begin errors++; $display("[TB] FAIL bp_data[%0d]: got %h expected %h", i, bus10.out_data, PT_C); end
      checks++; if (bus10.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", i, bus10.in_ready); end
    end
    bus10.out_ready = 1'b1;
    tick();
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus10.out_valid === 1'b1) seen++;
      tick();
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL bp_single_transfer: got %0d extra valid cycles expected 0", seen); end
  endtask

  task automatic test_reset_mid;
    int cnt, seen;
    expand_key(KEY_C1, 10);
    offer10(CT_C1);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (busy10 !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy10); end
    checks++; if (rk_idx10 !== 4'd10) begin errors++; $display("[TB] FAIL rstmid_rk_idx: got %0d expected 10", rk_idx10); end
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      if (bus10.out_valid !== 1'b0) seen++;
      tick();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus10.out_valid !== 1'b0) seen++;
      tick();
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL rstmid_spurious_valid: got %0d cycles expected 0", seen); end
    offer10(CT_C1);
    wait_out10(cnt);
    checks++; if (cnt != 10) begin errors++; $display("[TB] FAIL rstmid_latency: got %0d expected 10", cnt); end
    checks++; if (bus10.out_data !== PT_C) begin errors++; $display("[TB] FAIL rstmid_data: got %h expected %h", bus10.out_data, PT_C); end
    tick();
  endtask

  task automatic test_busy_ignore;
    int cnt;
    expand_key(KEY_C1, 10);
    offer10(CT_C1);
    cnt = 0;
    while (bus10.out_valid !== 1'b1 && cnt < 40) begin
      checks++; if (bus10.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ignore_in_ready[%0d]: got %b expected 0", cnt, bus10.in_ready); end
      bus10.in_valid = 1'($urandom_range(0, 1));
      bus10.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      cnt++;
    end
    bus10.in_valid = 1'b0;
    checks++; if (cnt != 10) begin errors++; $display("[TB] FAIL ignore_latency: got %0d expected 10", cnt); end
    checks++; if (bus10.out_data !== PT_C) begin errors++; $display("[TB] FAIL ignore_data: got %h expected %h", bus10.out_data, PT_C); end
    tick();
  endtask

`ifdef AES_INV_ENGINE_ABORT_EN
  task automatic test_abort;
    int cnt, seen;
    expand_key(KEY_C1, 10);
    offer10(CT_C1);
    tick();
    abort10 = 1'b1;
    tick();
    abort10 = 1'b0;
    checks++; if (busy10 !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy10); end
    checks++; if (bus10.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_in_ready: got %b expected 1", bus10.in_ready); end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus10.out_valid !== 1'b0) seen++;
      tick();
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL abort_spurious_valid: got %0d cycles expected 0", seen); end
    offer10(CT_C1);
    wait_out10(cnt);
    checks++; if (cnt != 10) begin errors++; $display("[TB] FAIL abort_next_latency: got %0d expected 10", cnt); end
    checks++; if (bus10.out_data !== PT_C) begin errors++; $display("[TB] FAIL abort_next_data: got %h expected %h", bus10.out_data, PT_C); end
    tick();
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    bus10.in_valid  = 1'b0;
    bus10.in_data   = '0;
    bus10.out_ready = 1'b1;
    bus14.in_valid  = 1'b0;
    bus14.in_data   = '0;
    bus14.out_ready = 1'b1;
`ifdef AES_INV_ENGINE_ABORT_EN
    abort10 = 1'b0;
    abort14 = 1'b0;
`endif
    build_sbox();
    test_reset();
    test_aes128();
    test_fips_b();
    test_aes256();
    test_backpressure();
    test_reset_mid();
    test_busy_ignore();
`ifdef AES_INV_ENGINE_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
